// File: rtl/doodle_pkg.sv
// Shared types and constants for the accelerometer tilt path.
// Pure declarations: no logic, no latency, no flow control.
package doodle_pkg;

   typedef enum logic [1:0] {
      CENTER = 2'd0,
      LEFT   = 2'd1,
      RIGHT  = 2'd2
   } tilt_state_t;

   localparam int AXIS_W = 5;
   localparam int SUM_W  = 7;

   // Field positions inside the 15-bit {x, y, z} accelerometer word
   localparam int ACL_X_LSB = 10;
   localparam int ACL_Y_LSB = 5;
   localparam int ACL_Z_LSB = 0;

endpackage

// File: rtl/tilt_avg4.sv
// 4-sample moving average of the lateral axis; avg and its valid flag are registered 1 cycle after a sample.
// No backpressure: every sample is accepted; flush clears the window synchronously.
module tilt_avg4
   import doodle_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     sample_vld_i,
   input  logic signed [AXIS_W-1:0] sample_dat_i,
   input  logic                     flush_i,
   output logic signed [AXIS_W-1:0] avg_dat_o,
   output logic                     avg_vld_o
);

   logic signed [AXIS_W-1:0] w_q [4];
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [SUM_W-1:0]  sum_d;
   logic signed [AXIS_W-1:0] avg_q;
   logic                     vld_q;

   // Running sum: add the newest sample, drop the one leaving the window
   always_comb begin
      sum_d = sum_q + SUM_W'(sample_dat_i) - SUM_W'(w_q[3]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4; i++) w_q[i] <= '0;
         sum_q <= '0;
         avg_q <= '0;
         vld_q <= 1'b0;
      end else if (flush_i) begin
         for (int i = 0; i < 4; i++) w_q[i] <= '0;
         sum_q <= '0;
         avg_q <= '0;
         vld_q <= 1'b0;
      end else if (sample_vld_i) begin
         w_q[0] <= sample_dat_i;
         for (int i = 1; i < 4; i++) w_q[i] <= w_q[i-1];
         sum_q <= sum_d;
         avg_q <= sum_d[SUM_W-1:2];
         vld_q <= 1'b1;
      end else begin
         vld_q <= 1'b0;
      end
   end

   assign avg_dat_o = avg_q;
   assign avg_vld_o = vld_q;

endmodule

// File: rtl/acl_tilt_filter.sv
// Averaged, hysteresis-filtered left/right tilt with saturated intensity and staleness watchdog; 2-cycle latency.
// No backpressure: one out_valid per acl_valid strobe, full rate; watchdog forces centre without out_valid.
module acl_tilt_filter
   import doodle_pkg::*;
#(
   parameter int ENTER_TH       = 2,
   parameter int EXIT_TH        = 1,
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int AXIS_LSB       = ACL_Y_LSB
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [14:0] acl_data,
   input  logic        acl_valid,
   output logic        tilt_left,
   output logic        tilt_right,
   output logic [3:0]  tilt_intensity,
   output logic        out_valid,
   output logic        stale
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic signed [AXIS_W-1:0] ENTER_POS = AXIS_W'(ENTER_TH);
   localparam logic signed [AXIS_W-1:0] ENTER_NEG = AXIS_W'(-ENTER_TH);
   localparam logic signed [AXIS_W-1:0] EXIT_POS  = AXIS_W'(EXIT_TH);
   localparam logic signed [AXIS_W-1:0] EXIT_NEG  = AXIS_W'(-EXIT_TH);

   logic signed [AXIS_W-1:0] sample;
   logic signed [AXIS_W-1:0] avg;
   logic                     avg_vld;
   logic                     fire;
   logic                     acl_unused;

   logic [CNT_W-1:0] cnt_q;
   logic             stale_q;
   tilt_state_t      state_q, state_d;
   logic [3:0]       inten_q, inten_d;
   logic             out_vld_q, out_vld_d;

   logic [AXIS_W:0]  avg_ext;
   logic [AXIS_W:0]  mag;
   logic [3:0]       sat;

   assign sample     = acl_data[AXIS_LSB +: AXIS_W];
   assign acl_unused = ^acl_data;

   // A strobe in the would-be firing cycle wins over the watchdog
   assign fire = ~acl_valid & (cnt_q == CNT_LAST);

   tilt_avg4 u_avg (
      .clk_i        (Clk),
      .rst_ni       (Reset_n),
      .sample_vld_i (acl_valid),
      .sample_dat_i (sample),
      .flush_i      (fire),
      .avg_dat_o    (avg),
      .avg_vld_o    (avg_vld)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q   <= '0;
         stale_q <= 1'b0;
      end else if (acl_valid) begin
         cnt_q   <= '0;
         stale_q <= 1'b0;
      end else if (fire) begin
         stale_q <= 1'b1;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // |avg| needs one extra bit so that -16 does not wrap
   always_comb begin
      avg_ext = {avg[AXIS_W-1], avg};
      mag     = avg_ext[AXIS_W] ? (~avg_ext + 1'b1) : avg_ext;
      sat     = (|mag[AXIS_W:4]) ? 4'hF : mag[3:0];
   end

   always_comb begin
      state_d   = state_q;
      inten_d   = inten_q;
      out_vld_d = 1'b0;
      if (fire) begin
         state_d = CENTER;
         inten_d = '0;
      end else if (avg_vld) begin
         out_vld_d = 1'b1;
         unique case (state_q)
            CENTER: begin
               if (avg >= ENTER_POS)      state_d = LEFT;
               else if (avg <= ENTER_NEG) state_d = RIGHT;
            end
            LEFT: begin
               if (avg <= ENTER_NEG)      state_d = RIGHT;
               else if (avg < EXIT_POS)   state_d = CENTER;
            end
            RIGHT: begin
               if (avg >= ENTER_POS)      state_d = LEFT;
               else if (avg > EXIT_NEG)   state_d = CENTER;
            end
            default: state_d = CENTER;
         endcase
         inten_d = (state_d == CENTER) ? 4'd0 : sat;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= CENTER;
         inten_q   <= '0;
         out_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         inten_q   <= inten_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign tilt_left      = (state_q == LEFT);
   assign tilt_right     = (state_q == RIGHT);
   assign tilt_intensity = inten_q;
   assign out_valid      = out_vld_q;
   assign stale          = stale_q;

endmodule

// File: tb/tb_acl_tilt_filter.sv
// Randomised scoreboard bench for acl_tilt_filter against a window/queue reference model.
module tb_acl_tilt_filter;

   localparam int T     = 16;
   localparam int ENTER = 2;
   localparam int EXIT  = 1;
   localparam int MC = 0, ML = 1, MR = 2;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [14:0] acl_data = '0;
   logic        acl_valid = 1'b0;
   logic        tilt_left, tilt_right;
   logic [3:0]  tilt_intensity;
   logic        out_valid, stale;

   always #5 Clk = ~Clk;

   acl_tilt_filter #(
      .ENTER_TH       (ENTER),
      .EXIT_TH        (EXIT),
      .TIMEOUT_CYCLES (T),
      .AXIS_LSB       (5)
   ) dut (
      .Clk            (Clk),
      .Reset_n        (Reset_n),
      .acl_data       (acl_data),
      .acl_valid      (acl_valid),
      .tilt_left      (tilt_left),
      .tilt_right     (tilt_right),
      .tilt_intensity (tilt_intensity),
      .out_valid      (out_valid),
      .stale          (stale)
   );

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      int left;
      int right;
      int inten;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   win[$];
   int   m_state = MC;
   int   idle_cnt = 0;
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int floor_div4(input int v);
      return (v >= 0) ? v / 4 : -((-v + 3) / 4);
   endfunction

   task automatic model_sample(input int s);
      int   sum;
      int   avg;
      int   mag;
      exp_t e;
      sum = 0;
      win.push_front(s);
      if (win.size() > 4) void'(win.pop_back());
      foreach (win[i]) sum += win[i];
      avg = floor_div4(sum);
      case (m_state)
         MC: if (avg >= ENTER) m_state = ML; else if (avg <= -ENTER) m_state = MR;
         ML: if (avg <= -ENTER) m_state = MR; else if (avg < EXIT) m_state = MC;
         default: if (avg >= ENTER) m_state = ML; else if (avg > -EXIT) m_state = MC;
      endcase
      mag = (avg < 0) ? -avg : avg;
      if (mag > 15) mag = 15;
      e.left  = (m_state == ML) ? 1 : 0;
      e.right = (m_state == MR) ? 1 : 0;
      e.inten = (m_state == MC) ? 0 : mag;
      e.cyc   = cyc + 2;
      sb.push_back(e);
      idle_cnt = 0;
   endtask

   task automatic model_idle();
      if (idle_cnt == T - 1) begin
         win.delete();
         m_state = MC;
      end else begin
         idle_cnt++;
      end
   endtask

   task automatic step(input bit v, input int s);
      @(posedge Clk);
      #1;
      acl_valid = v;
      acl_data  = {5'($urandom), 5'(s), 5'($urandom)};
      if (v) model_sample(s);
      else   model_idle();
   endtask

   task automatic do_reset();
      Reset_n   = 1'b0;
      acl_valid = 1'b0;
      acl_data  = '0;
      sb.delete();
      win.delete();
      m_state  = MC;
      idle_cnt = 0;
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      model_idle();
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge Clk);
         if (Reset_n) begin
            if (out_valid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out_valid", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("out_valid_cycle", cyc, e.cyc);
                  chk("tilt_left", int'(tilt_left), e.left);
                  chk("tilt_right", int'(tilt_right), e.right);
                  chk("tilt_intensity", int'(tilt_intensity), e.inten);
                  chk("stale_at_out", int'(stale), 0);
               end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
               e = sb.pop_front();
               chk("out_valid_missing", 0, 1);
            end
         end
      end
   endtask

   initial begin
      int s;
      int g;
      fork
         monitor();
      join_none

      do_reset();
      chk("reset_tilt_left", int'(tilt_left), 0);
      chk("reset_tilt_right", int'(tilt_right), 0);
      chk("reset_intensity", int'(tilt_intensity), 0);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_stale", int'(stale), 0);

      repeat (4) step(1, 8);
      repeat (4) step(1, 2);
      repeat (4) step(1, 1);
      repeat (4) step(1, 0);
      repeat (4) step(1, -16);
      repeat (4) step(1, 15);

      // Watchdog: hold LEFT, then starve the input
      repeat (4) step(1, 8);
      repeat (T + 4) step(0, 0);
      chk("wd_stale", int'(stale), 1);
      chk("wd_tilt_left", int'(tilt_left), 0);
      chk("wd_tilt_right", int'(tilt_right), 0);
      chk("wd_intensity", int'(tilt_intensity), 0);
      step(1, 8);
      step(0, 0);
      chk("wd_stale_cleared", int'(stale), 0);

      // Strobe lands exactly on the firing cycle
      step(1, 8);
      repeat (T - 1) step(0, 0);
      step(1, 8);
      step(0, 0);
      chk("exact_fire_stale", int'(stale), 0);
      step(0, 0);

      for (int n = 0; n < 300; n++) begin
         s = int'($urandom_range(0, 31));
         if (s > 15) s -= 32;
         g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 2, T + 2))
                                          : int'($urandom_range(0, 2));
         repeat (g) step(0, 0);
         step(1, s);
      end
      repeat (6) step(0, 0);
      chk("scoreboard_drained", sb.size(), 0);

      // Asynchronous reset in the middle of a burst
      do_reset();
      repeat (4) step(1, 8);
      @(posedge Clk);
      #3;
      chk("pre_reset_tilt_left", int'(tilt_left), 1);
      chk("pre_reset_out_valid", int'(out_valid), 1);
      Reset_n = 1'b0;
      #1;
      chk("async_tilt_left", int'(tilt_left), 0);
      chk("async_tilt_right", int'(tilt_right), 0);
      chk("async_intensity", int'(tilt_intensity), 0);
      chk("async_out_valid", int'(out_valid), 0);
      chk("async_stale", int'(stale), 0);
      do_reset();
      repeat (3) step(1, -8);
      repeat (4) step(0, 0);
      chk("final_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/acl_tilt_filter.md
# acl_tilt_filter

Conditions raw accelerometer samples from `spi_master` into debounced left/right tilt commands and a 4-bit tilt intensity for `vga_controller` and the tilt LEDs. Each sample passes through a 4-sample moving average on the lateral axis. A hysteresis state machine then classifies the result, so the doodle stops jittering near level. A staleness watchdog forces the output to centre if the SPI stream stops.

## Interface
Parameters:
- `ENTER_TH`, 2: minimum |average| needed to enter LEFT or RIGHT.
- `EXIT_TH`, 1: a tilted state is left when |average| falls below this on its side. Must be ≤ `ENTER_TH`.
- `TIMEOUT_CYCLES`, 1_000_000: Clk cycles without `acl_valid` before the watchdog fires (10 ms at 100 MHz).
- `AXIS_LSB`, 5: LSB index of the 5-bit signed lateral axis field in `acl_data`.

Ports (one clock; reset is asynchronous and active-low):
- `Clk`  in  1: system clock (ClkPort domain).
- `Reset_n`  in  1: asynchronous, active-low reset.
- `acl_data`  in  15: `{x[4:0], y[4:0], z[4:0]}` from `spi_master`, already synchronised to Clk. Sampled only when `acl_valid`=1.
- `acl_valid`  in  1: single-cycle strobe marking a new sample.
- `tilt_left`  out  1: state is LEFT.
- `tilt_right`  out  1: state is RIGHT.
- `tilt_intensity`  out  4: saturated |average|. Forced to 0 in CENTER.
- `out_valid`  out  1: one-cycle pulse when outputs are updated from a sample.
- `stale`  out  1: watchdog has fired and no sample has arrived since.

## Operation
- Axis: `s = $signed(acl_data[AXIS_LSB+4:AXIS_LSB])`, range −16..15. Negative means tilted right; positive means tilted left.
- Window: 4-entry shift register `w[0..3]` plus a running `sum` (7-bit signed, range −64..60).
  - On `acl_valid`: `sum <= sum + s − w[3]`, then shift `s` into `w[0]`.
  - After reset the window and `sum` are 0, so the first three averages are diluted by zeros. This is intended.
- Average: `avg = sum >>> 2` (arithmetic shift, rounds toward −∞), 5-bit signed.
- FSM states: CENTER, LEFT, RIGHT. Reset state is CENTER. The FSM evaluates only in the cycle after `acl_valid`, using the new `avg`.
  - CENTER → LEFT if `avg ≥ ENTER_TH`.
  - CENTER → RIGHT if `avg ≤ −ENTER_TH`.
  - Otherwise the FSM stays in CENTER.
  - LEFT → RIGHT if `avg ≤ −ENTER_TH`. Else LEFT → CENTER if `avg < EXIT_TH`. Otherwise it stays in LEFT.
  - RIGHT → LEFT if `avg ≥ ENTER_TH`. Else RIGHT → CENTER if `avg > −EXIT_TH`. Otherwise it stays in RIGHT.
- Intensity: `min(|avg|, 15)`; avg = −16 yields 15. It is registered together with the state and is 0 whenever the next state is CENTER.
- Watchdog: counter cleared by every `acl_valid`, otherwise incremented.
  - On reaching `TIMEOUT_CYCLES−1` it fires: window and `sum` clear to 0, state → CENTER, intensity → 0, `stale`=1, counter holds.
  - A watchdog firing does not pulse `out_valid`.
  - `stale` clears on the next `acl_valid`.
- `acl_valid` in the same cycle the watchdog would fire: the sample wins, the counter clears and no flush occurs.
- Reset values: `tilt_left`=0, `tilt_right`=0, `tilt_intensity`=0, `out_valid`=0, `stale`=0. Counter, window and `sum` are also 0.
- Reset asserted mid-operation returns every register to these values immediately, with no pending output.

## Timing
- Cycle 0: `acl_valid`=1 and `acl_data` is captured.
- Cycle 1: window and `sum` are updated.
- Cycle 2: state, `tilt_*`, `tilt_intensity` and `out_valid`=1 appear. Latency is 2 cycles.
- Back-to-back `acl_valid` on consecutive cycles is supported at full rate. Each strobe produces its own `out_valid` 2 cycles later.
- All outputs are registered. There is no combinational path from inputs to outputs.
- The watchdog takes effect on outputs 1 cycle after the counter reaches `TIMEOUT_CYCLES−1`.

## Structure
- `doodle_pkg` holds:
  - the `tilt_state_t` encoding (CENTER=2'd0, LEFT=2'd1, RIGHT=2'd2);
  - `AXIS_W`=5 and `SUM_W`=7;
  - the accelerometer field LSB constants (X=10, Y=5, Z=0).
- Sub-module `tilt_avg4` contains the window, the running sum and the registered `avg` plus its valid flag. It has a synchronous `flush` input driven by the watchdog.
- The top of this block contains the FSM, the intensity saturation and the watchdog.
- In `doodle_top`, this block replaces the inline `parse_left`/`parse_right`/GET_SENSITIVITY logic.

## Test plan
- Reset, then four samples with axis=+8 → after sample 1 avg=2 gives LEFT, intensity=2. After sample 4 avg=8, intensity=8. Each `out_valid` arrives 2 cycles after its strobe.
- Fill window at avg=+2 (LEFT), then feed axis=+1 until avg=1 → stays LEFT. Feed 0s until avg=0 → CENTER with intensity=0 (hysteresis check).
- Fill window at −16 → RIGHT with intensity=15 (saturation). Then feed +15 ×4 → direct RIGHT→LEFT with no CENTER cycle; final intensity=15.
- Hold LEFT, stop strobes for `TIMEOUT_CYCLES` (set to 16 in the bench) → CENTER, `stale`=1, no `out_valid`. The next sample of +8 gives avg=2, LEFT, and `stale`=0.
- Strobe `acl_valid` on the exact watchdog-fire cycle → no flush and `stale` stays 0. Then deassert `Reset_n` asynchronously mid-stream → all outputs 0 within the same cycle.
